systolic_seq_ctrl: RTL



---
 rtl/systolic_seq_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the 32x32 systolic multiply array: streams SRAM words into the
// array, drives its cycle/diagonal controls and hands finished diagonals to write-back.
module systolic_seq_ctrl #(
  parameter int unsigned ARRAY_SIZE = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned FIRST_OUT  = 33
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            num_tiles,
  input  logic [ADDR_WIDTH-1:0] w_base,
  input  logic [ADDR_WIDTH-1:0] d_base,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_ren,
  output logic [ADDR_WIDTH-1:0] sram_raddr_w,
  output logic [ADDR_WIDTH-1:0] sram_raddr_d,
  output logic                  alu_start,
  output logic [8:0]            cycle_num,
  output logic [5:0]            matrix_index,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0]            out_tile
);

  localparam logic [8:0] TILE_PERIOD = 9'(2 * ARRAY_SIZE);
  localparam logic [8:0] TAIL_C      = 9'(ARRAY_SIZE - 1);
  localparam logic [8:0] FIRST_C     = 9'(FIRST_OUT);
  localparam logic [5:0] NO_DIAG     = 6'(2 * ARRAY_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            tiles_q, tiles_d;
  logic [ADDR_WIDTH-1:0] w_base_q, w_base_d;
  logic [ADDR_WIDTH-1:0] d_base_q, d_base_d;
  logic [8:0]            c_q, c_d;
  logic                  busy_q, busy_d;

  logic       in_run;
  logic       past_first;
  logic       stall;
  logic       addr_en;
  logic [8:0] last_c;
  logic [8:0] k;
  logic [8:0] addr_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tiles_q  <= 3'd1;
      w_base_q <= '0;
      d_base_q <= '0;
      c_q      <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tiles_q  <= tiles_d;
      w_base_q <= w_base_d;
      d_base_q <= d_base_d;
      c_q      <= c_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tiles_d      = tiles_q;
    w_base_d     = w_base_q;
    d_base_d     = d_base_q;
    c_d          = c_q;
    sram_ren     = 1'b0;
    addr_en      = 1'b0;
    addr_off     = '0;
    last_c       = 9'(tiles_q) * TILE_PERIOD + TAIL_C;
    in_run       = (state_q == S_RUN);
    past_first   = in_run && (c_q >= FIRST_C);
    k            = c_q - FIRST_C;
    out_valid    = past_first && (k[5:0] != NO_DIAG);
    stall        = out_valid && !out_ready;
    alu_start    = in_run && !stall && !abort;
    done         = (state_q == S_DONE) && !abort;
    cycle_num    = in_run ? c_q : '0;
    matrix_index = past_first ? k[5:0] : '0;
    out_tile     = past_first ? k[8:6] : '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          tiles_d  = (num_tiles == 3'd0) ? 3'd1 : num_tiles;
          w_base_d = w_base;
          d_base_d = d_base;
          c_d      = '0;
          state_d  = S_PRIME;
        end
      end
      S_PRIME: begin
        addr_en  = 1'b1;
        sram_ren = !abort;
        c_d      = '0;
        state_d  = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        addr_en = 1'b1;
        // A stalled cycle re-presents the address already issued, so the array resumes on identical data.
        addr_off = stall ? c_q : c_q + 9'd1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (!stall) begin
          sram_ren = (c_q != last_c);
          if (c_q == last_c) begin
            state_d = S_DONE;
          end else begin
            c_d = c_q + 9'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d       = (state_d != S_IDLE);
    busy         = busy_q;
    sram_raddr_w = addr_en ? w_base_q + ADDR_WIDTH'(addr_off) : '0;
    sram_raddr_d = addr_en ? d_base_q + ADDR_WIDTH'(addr_off) : '0;
  end

endmodule
